// File: rtl/riscv_zero_pkg.sv
// Shared definitions for the riscv_zero pipeline control logic:
// writeback-source and forwarding-select encodings plus the shadow-slot
// record kept for each in-flight stage.
package riscv_zero_pkg;

    // Register address width carried inside a shadow slot.
    localparam int SLOT_RA_W = 5;

    // decode writeback_source value that marks a load result
    localparam logic [1:0] WB_SRC_LOAD = 2'b01;

    // EX operand select encodings
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // One in-flight instruction as seen by the hazard logic
    typedef struct packed {
        logic                 valid;
        logic [SLOT_RA_W-1:0] rd;
        logic                 we;
        logic                 is_load;
    } slot_t;

    // True when a slot will write register rs and the reader actually uses it
    function automatic logic slot_hit(input slot_t s, input logic [SLOT_RA_W-1:0] rs,
                                      input logic use_rs);
        return s.valid && s.we && (s.rd == rs) && use_rs;
    endfunction

endpackage

// File: rtl/riscv_zero_sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module riscv_zero_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Increment on enable unless already saturated
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_en && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/riscv_zero_hazard_ctrl.sv
// Pipeline hazard controller for the five-stage riscv_zero core.
// Tracks destination registers in flight in EX/MEM/WB and derives stall,
// bubble, flush, memory-hold and registered forwarding selects.
module riscv_zero_hazard_ctrl
    import riscv_zero_pkg::*;
#(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_wb_enable,
    input  logic [1:0]       id_wb_source,
    input  logic             ex_redirect,
    input  logic             dmem_busy,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic             hold_mem,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] loaduse_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Shadow pipeline state and forwarding selects
    slot_t      r_ex, r_mem, r_wb;
    logic [1:0] r_fwd_a, r_fwd_b;

    slot_t      w_ex_next, w_mem_next, w_wb_next;
    logic [1:0] w_fwd_a_next, w_fwd_b_next;

    slot_t      w_id_slot;
    logic       w_hit_ex_rs1, w_hit_ex_rs2, w_hit_mem_rs1, w_hit_mem_rs2;
    logic       w_load_use;
    logic [1:0] w_fwd_a_calc, w_fwd_b_calc;
    logic       w_loaduse_inc, w_flush_inc;

    // Decode view of the ID instruction; writes to x0 never create a hazard
    assign w_id_slot.valid   = id_valid;
    assign w_id_slot.rd      = id_rd;
    assign w_id_slot.we      = id_wb_enable && (id_rd != '0);
    assign w_id_slot.is_load = (id_wb_source == WB_SRC_LOAD);

    assign w_hit_ex_rs1  = slot_hit(r_ex,  id_rs1, id_use_rs1);
    assign w_hit_ex_rs2  = slot_hit(r_ex,  id_rs2, id_use_rs2);
    assign w_hit_mem_rs1 = slot_hit(r_mem, id_rs1, id_use_rs1);
    assign w_hit_mem_rs2 = slot_hit(r_mem, id_rs2, id_use_rs2);

    // A load in EX cannot forward yet, so a dependent ID instruction must wait
    assign w_load_use = id_valid && r_ex.is_load && (w_hit_ex_rs1 || w_hit_ex_rs2);

    // Youngest producer wins: EX/MEM result before MEM/WB result
    assign w_fwd_a_calc = (w_hit_ex_rs1 && !r_ex.is_load) ? FWD_EXMEM :
                          w_hit_mem_rs1                   ? FWD_MEMWB : FWD_RF;
    assign w_fwd_b_calc = (w_hit_ex_rs2 && !r_ex.is_load) ? FWD_EXMEM :
                          w_hit_mem_rs2                   ? FWD_MEMWB : FWD_RF;

    // Prioritised control: memory busy, then redirect, then load-use, then advance
    always_comb begin
        stall_if      = 1'b0;
        stall_id      = 1'b0;
        bubble_ex     = 1'b0;
        flush_id      = 1'b0;
        hold_mem      = 1'b0;
        w_loaduse_inc = 1'b0;
        w_flush_inc   = 1'b0;
        w_ex_next     = '0;
        w_mem_next    = r_ex;
        w_wb_next     = r_mem;
        w_fwd_a_next  = FWD_RF;
        w_fwd_b_next  = FWD_RF;

        if (reset) begin
            // outputs stay 0; registers are cleared by the sequential block
        end else if (dmem_busy) begin
            // Redirect is dropped here; the branch re-asserts it once EX moves
            stall_if     = 1'b1;
            stall_id     = 1'b1;
            hold_mem     = 1'b1;
            w_ex_next    = r_ex;
            w_mem_next   = r_mem;
            w_wb_next    = '0;
            w_fwd_a_next = r_fwd_a;
            w_fwd_b_next = r_fwd_b;
        end else if (ex_redirect) begin
            flush_id    = 1'b1;
            bubble_ex   = 1'b1;
            w_flush_inc = 1'b1;
        end else if (w_load_use) begin
            stall_if      = 1'b1;
            stall_id      = 1'b1;
            bubble_ex     = 1'b1;
            w_loaduse_inc = 1'b1;
        end else begin
            w_ex_next    = w_id_slot;
            w_fwd_a_next = w_fwd_a_calc;
            w_fwd_b_next = w_fwd_b_calc;
        end
    end

    // Shadow slots and forwarding select registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex    <= '0;
            r_mem   <= '0;
            r_wb    <= '0;
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else begin
            r_ex    <= w_ex_next;
            r_mem   <= w_mem_next;
            r_wb    <= w_wb_next;
            r_fwd_a <= w_fwd_a_next;
            r_fwd_b <= w_fwd_b_next;
        end
    end

    // The WB slot is drained while memory is stalled, so no retire is double-counted
    a_wb_drained_after_busy: assert property (@(posedge clk) disable iff (reset)
        $past(dmem_busy) |-> !r_wb.valid);

    assign fwd_a = r_fwd_a;
    assign fwd_b = r_fwd_b;

    riscv_zero_sat_counter #(.CNT_W(CNT_W)) u_loaduse_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_loaduse_inc),
        .o_count (loaduse_cnt)
    );

    riscv_zero_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_flush_inc),
        .o_count (flush_cnt)
    );

endmodule

// File: tb/tb_riscv_zero_hazard_ctrl.sv
// Directed testbench for riscv_zero_hazard_ctrl: one task per scenario,
// each with inline hand-computed expectations.
module tb_riscv_zero_hazard_ctrl;

    localparam int RA_W  = 5;
    localparam int CNT_W = 16;

    logic             clk;
    logic             reset;
    logic             id_valid;
    logic [RA_W-1:0]  id_rs1, id_rs2, id_rd;
    logic             id_use_rs1, id_use_rs2, id_wb_enable;
    logic [1:0]       id_wb_source;
    logic             ex_redirect, dmem_busy;
    logic             stall_if, stall_id, bubble_ex, flush_id, hold_mem;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] loaduse_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    riscv_zero_hazard_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_wb_enable (id_wb_enable),
        .id_wb_source (id_wb_source),
        .ex_redirect  (ex_redirect),
        .dmem_busy    (dmem_busy),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .bubble_ex    (bubble_ex),
        .flush_id     (flush_id),
        .hold_mem     (hold_mem),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .loaduse_cnt  (loaduse_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are changed and outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic we, input logic [1:0] src);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_wb_enable = we; id_wb_source = src;
    endtask

    task automatic drain();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00);
        ex_redirect = 1'b0;
        dmem_busy   = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drain();
        reset = 1'b0;
        #1;
        checks++; if ({stall_if, stall_id, bubble_ex, flush_id, hold_mem} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got=%05b exp=00000", {stall_if, stall_id, bubble_ex, flush_id, hold_mem}); end
        checks++; if ({fwd_a, fwd_b} !== 4'b0) begin
            errors++; $display("FAIL reset_fwd got=%04b exp=0000", {fwd_a, fwd_b}); end
        checks++; if (loaduse_cnt !== '0 || flush_cnt !== '0) begin
            errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", loaduse_cnt, flush_cnt); end
        $display("tx reset: done");
    endtask

    task automatic test_load_use();
        set_id(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd5, 1'b1, 2'b01);   // lw x5
        tick();
        set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 2'b00);   // add x6, x5, ...
        #1;
        checks++; if ({stall_if, stall_id, bubble_ex, flush_id} !== 4'b1110) begin
            errors++; $display("FAIL lu_stall got=%04b exp=1110", {stall_if, stall_id, bubble_ex, flush_id}); end
        tick();
        checks++; if ({stall_if, stall_id, bubble_ex} !== 3'b000) begin
            errors++; $display("FAIL lu_release got=%03b exp=000", {stall_if, stall_id, bubble_ex}); end
        checks++; if (fwd_a !== 2'b00) begin
            errors++; $display("FAIL lu_bubble_fwd got=%02b exp=00", fwd_a); end
        checks++; if (loaduse_cnt !== 16'd1) begin
            errors++; $display("FAIL lu_cnt got=%0d exp=1", loaduse_cnt); end
        tick();
        checks++; if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
            errors++; $display("FAIL lu_fwd got=%02b/%02b exp=10/00", fwd_a, fwd_b); end
        $display("tx load_use: loaduse_cnt=%0d", loaduse_cnt);
        drain();
    endtask

    task automatic test_fwd_priority();
        set_id(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 2'b01);   // lw x3
        tick();
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 2'b00);   // addi x3, x1
        #1;
        checks++; if (stall_if !== 1'b0) begin
            errors++; $display("FAIL fp_nostall got=%0b exp=0", stall_if); end
        tick();
        set_id(1'b1, 5'd0, 5'd3, 1'b0, 1'b1, 5'd4, 1'b1, 2'b00);   // add x4, ?, x3
        tick();
        checks++; if (fwd_b !== 2'b01 || fwd_a !== 2'b00) begin
            errors++; $display("FAIL fp_ex_wins got=%02b/%02b exp=00/01", fwd_a, fwd_b); end
        drain();
        set_id(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 2'b01);   // lw x0
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 2'b00);   // addi x0, x0
        #1;
        checks++; if ({stall_if, bubble_ex} !== 2'b00) begin
            errors++; $display("FAIL fp_x0_nostall got=%02b exp=00", {stall_if, bubble_ex}); end
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 2'b00);   // reads x0 on rs2
        tick();
        checks++; if (fwd_b !== 2'b00) begin
            errors++; $display("FAIL fp_x0_fwd got=%02b exp=00", fwd_b); end
        $display("tx fwd_priority: done");
        drain();
    endtask

    task automatic test_redirect();
        set_id(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd7, 1'b1, 2'b01);   // lw x7
        tick();
        set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 2'b00);   // dependent add
        ex_redirect = 1'b1;
        #1;
        checks++; if ({flush_id, bubble_ex, stall_if, stall_id} !== 4'b1100) begin
            errors++; $display("FAIL rd_ctrl got=%04b exp=1100", {flush_id, bubble_ex, stall_if, stall_id}); end
        tick();
        ex_redirect = 1'b0;
        checks++; if (flush_cnt !== 16'd1 || loaduse_cnt !== 16'd1) begin
            errors++; $display("FAIL rd_cnt got=%0d/%0d exp=1/1", flush_cnt, loaduse_cnt); end
        $display("tx redirect: flush_cnt=%0d", flush_cnt);
        drain();
    endtask

    task automatic test_busy();
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 2'b00);   // addi x9
        tick();
        set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 2'b00);  // add x10, x9
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00);
        dmem_busy   = 1'b1;
        ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({hold_mem, stall_if, stall_id, flush_id, bubble_ex} !== 5'b11100) begin
                errors++; $display("FAIL busy_ctrl[%0d] got=%05b exp=11100", i, {hold_mem, stall_if, stall_id, flush_id, bubble_ex}); end
            checks++; if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
                errors++; $display("FAIL busy_fwd_hold[%0d] got=%02b/%02b exp=01/00", i, fwd_a, fwd_b); end
            tick();
        end
        dmem_busy = 1'b0;
        #1;
        checks++; if ({flush_id, bubble_ex, hold_mem, stall_if} !== 4'b1100) begin
            errors++; $display("FAIL busy_release got=%04b exp=1100", {flush_id, bubble_ex, hold_mem, stall_if}); end
        tick();
        ex_redirect = 1'b0;
        checks++; if (fwd_a !== 2'b00 || flush_cnt !== 16'd2) begin
            errors++; $display("FAIL busy_after got fwd=%02b cnt=%0d exp fwd=00 cnt=2", fwd_a, flush_cnt); end
        $display("tx busy: flush_cnt=%0d", flush_cnt);
        drain();
    endtask

    task automatic test_reset_mid_stall();
        set_id(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd12, 1'b1, 2'b01);  // lw x12
        tick();
        set_id(1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, 2'b00);
        #1;
        checks++; if (stall_if !== 1'b1) begin
            errors++; $display("FAIL rms_pre got=%0b exp=1", stall_if); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if ({stall_if, stall_id, bubble_ex, flush_id, hold_mem, fwd_a, fwd_b} !== 9'b0) begin
            errors++; $display("FAIL rms_outs got=%09b exp=000000000", {stall_if, stall_id, bubble_ex, flush_id, hold_mem, fwd_a, fwd_b}); end
        checks++; if (loaduse_cnt !== '0 || flush_cnt !== '0) begin
            errors++; $display("FAIL rms_cnt got=%0d/%0d exp=0/0", loaduse_cnt, flush_cnt); end
        tick();
        checks++; if (fwd_a !== 2'b00) begin
            errors++; $display("FAIL rms_fwd got=%02b exp=00", fwd_a); end
        $display("tx reset_mid_stall: done");
        drain();
    endtask

    task automatic test_saturation();
        ex_redirect = 1'b1;
        repeat (65534) tick();
        checks++; if (flush_cnt !== 16'hFFFE) begin
            errors++; $display("FAIL sat_pre got=%h exp=fffe", flush_cnt); end
        tick();
        checks++; if (flush_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL sat_full got=%h exp=ffff", flush_cnt); end
        repeat (4) tick();
        checks++; if (flush_cnt !== 16'hFFFF || loaduse_cnt !== 16'd0) begin
            errors++; $display("FAIL sat_hold got=%h/%0d exp=ffff/0", flush_cnt, loaduse_cnt); end
        ex_redirect = 1'b0;
        $display("tx saturation: flush_cnt=%h", flush_cnt);
    endtask

    initial begin
        reset = 1'b1;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00);
        ex_redirect = 1'b0;
        dmem_busy   = 1'b0;
        test_reset();
        test_load_use();
        test_fwd_priority();
        test_redirect();
        test_busy();
        test_reset_mid_stall();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
